// File: rtl/hazard_stall_ctrl_if.sv
// Pipeline-control bundle between the datapath hazard sources and hazard_stall_ctrl.
// master = datapath side (drives hazard inputs), slave = sequencer side (drives controls).
interface hazard_stall_ctrl_if;
  logic [4:0] id_rs1;
  logic [4:0] id_rs2;
  logic       id_uses_rs1;
  logic       id_uses_rs2;
  logic       ex_wb_load;
  logic [4:0] ex_wb_rd;
  logic       ex_redirect;
  logic       mem_memory_write;
  logic       mem_wb_load;
  logic       dmem_ready;
  logic       pc_en;
  logic       if_id_en;
  logic       if_id_flush;
  logic       id_ex_en;
  logic       id_ex_flush;
  logic       ex_mem_en;
  logic       ex_mem_flush;
  logic       mem_wb_en;
  logic       mem_wb_flush;
  logic       mem_fault;

  modport master (
    output id_rs1, id_rs2, id_uses_rs1, id_uses_rs2, ex_wb_load, ex_wb_rd,
           ex_redirect, mem_memory_write, mem_wb_load, dmem_ready,
    input  pc_en, if_id_en, if_id_flush, id_ex_en, id_ex_flush,
           ex_mem_en, ex_mem_flush, mem_wb_en, mem_wb_flush, mem_fault
  );

  modport slave (
    input  id_rs1, id_rs2, id_uses_rs1, id_uses_rs2, ex_wb_load, ex_wb_rd,
           ex_redirect, mem_memory_write, mem_wb_load, dmem_ready,
    output pc_en, if_id_en, if_id_flush, id_ex_en, id_ex_flush,
           ex_mem_en, ex_mem_flush, mem_wb_en, mem_wb_flush, mem_fault
  );
endinterface

// File: rtl/hazard_stall_ctrl.sv
// 5-stage pipeline sequencer: load-use, redirect and data-memory wait/timeout control.
// Optional HAZARD_STALL_CNT_EN adds a 32-bit stall_cycles counter output.
module hazard_stall_ctrl #(
  parameter int unsigned MEM_TIMEOUT = 16,
  parameter int unsigned TO_W        = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  hazard_stall_ctrl_if.slave   bus
`ifdef HAZARD_STALL_CNT_EN
  ,
  output logic [31:0]          stall_cycles
`endif
);

  typedef enum logic [1:0] {S_RUN, S_MEM_WAIT, S_FAULT} state_e;

  localparam logic [TO_W-1:0] TO_LIMIT = TO_W'(MEM_TIMEOUT);

  state_e          state_q, state_d;
  logic [TO_W-1:0] to_cnt_q, to_cnt_d;

  logic mem_access, mem_stall, load_use;
  logic pc_en, if_id_en, if_id_flush, id_ex_en, id_ex_flush;
  logic ex_mem_en, ex_mem_flush, mem_wb_en, mem_wb_flush, mem_fault;

  assign mem_access = bus.mem_memory_write | bus.mem_wb_load;
  assign mem_stall  = mem_access & ~bus.dmem_ready & (state_q != S_FAULT);
  assign load_use   = bus.ex_wb_load & (bus.ex_wb_rd != 5'd0) &
                      ((bus.id_uses_rs1 & (bus.id_rs1 == bus.ex_wb_rd)) |
                       (bus.id_uses_rs2 & (bus.id_rs2 == bus.ex_wb_rd)));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= S_RUN;
      to_cnt_q <= '0;
    end else begin
      state_q  <= state_d;
      to_cnt_q <= to_cnt_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    to_cnt_d     = to_cnt_q;
    pc_en        = 1'b1;
    if_id_en     = 1'b1;
    if_id_flush  = 1'b0;
    id_ex_en     = 1'b1;
    id_ex_flush  = 1'b0;
    ex_mem_en    = 1'b1;
    ex_mem_flush = 1'b0;
    mem_wb_en    = 1'b1;
    mem_wb_flush = 1'b0;
    mem_fault    = 1'b0;

    if (state_q == S_FAULT) begin
      pc_en        = 1'b0;
      if_id_en     = 1'b0;
      id_ex_en     = 1'b0;
      ex_mem_flush = 1'b1;
      mem_wb_flush = 1'b1;
      mem_fault    = 1'b1;
      state_d      = S_RUN;
      to_cnt_d     = '0;
    end else if (mem_stall) begin
      // Redirect/load-use held in EX/ID stay frozen and are acted on at release.
      pc_en        = 1'b0;
      if_id_en     = 1'b0;
      id_ex_en     = 1'b0;
      ex_mem_en    = 1'b0;
      mem_wb_flush = 1'b1;
      if (state_q == S_RUN) begin
        state_d  = S_MEM_WAIT;
        to_cnt_d = TO_W'(1);
      end else if (to_cnt_q >= TO_LIMIT) begin
        state_d  = S_FAULT;
      end else if (to_cnt_q != '1) begin
        to_cnt_d = to_cnt_q + TO_W'(1);
      end
    end else begin
      if (state_q == S_MEM_WAIT) begin
        state_d  = S_RUN;
        to_cnt_d = '0;
      end
      if (bus.ex_redirect) begin
        if_id_flush = 1'b1;
        id_ex_flush = 1'b1;
      end else if (load_use) begin
        pc_en       = 1'b0;
        if_id_en    = 1'b0;
        id_ex_flush = 1'b1;
      end
    end

    // Reset forces a safe pipeline: nothing written, every stage flushed.
    if (!rst) begin
      pc_en        = 1'b0;
      if_id_en     = 1'b0;
      id_ex_en     = 1'b0;
      ex_mem_en    = 1'b0;
      mem_wb_en    = 1'b0;
      if_id_flush  = 1'b1;
      id_ex_flush  = 1'b1;
      ex_mem_flush = 1'b1;
      mem_wb_flush = 1'b1;
      mem_fault    = 1'b0;
    end
  end

  assign bus.pc_en        = pc_en;
  assign bus.if_id_en     = if_id_en;
  assign bus.if_id_flush  = if_id_flush;
  assign bus.id_ex_en     = id_ex_en;
  assign bus.id_ex_flush  = id_ex_flush;
  assign bus.ex_mem_en    = ex_mem_en;
  assign bus.ex_mem_flush = ex_mem_flush;
  assign bus.mem_wb_en    = mem_wb_en;
  assign bus.mem_wb_flush = mem_wb_flush;
  assign bus.mem_fault    = mem_fault;

`ifdef HAZARD_STALL_CNT_EN
  logic [31:0] stall_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stall_q <= '0;
    end else if (!pc_en) begin
      stall_q <= stall_q + 32'd1;
    end
  end

  assign stall_cycles = stall_q;
`endif

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// Self-checking bench for hazard_stall_ctrl (MEM_TIMEOUT = 4): vector table plus
// hand-written multi-cycle sequences, checked through an expected-result queue.
module tb_hazard_stall_ctrl;

  logic clk;
  logic rst;

  hazard_stall_ctrl_if bus ();

`ifdef HAZARD_STALL_CNT_EN
  logic [31:0] stall_cycles;
`endif

  hazard_stall_ctrl #(.MEM_TIMEOUT(4), .TO_W(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
`ifdef HAZARD_STALL_CNT_EN
    ,
    .stall_cycles (stall_cycles)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Bit order: pc_en, if_id_en, if_id_flush, id_ex_en, id_ex_flush,
  //            ex_mem_en, ex_mem_flush, mem_wb_en, mem_wb_flush, mem_fault
  localparam logic [9:0] E_NORM  = 10'b1101010100;
  localparam logic [9:0] E_LU    = 10'b0001110100;
  localparam logic [9:0] E_RD    = 10'b1111110100;
  localparam logic [9:0] E_STALL = 10'b0000000110;
  localparam logic [9:0] E_FAULT = 10'b0000011111;
  localparam logic [9:0] E_RESET = 10'b0010101010;

  typedef struct {
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic       u1;
    logic       u2;
    logic       ld;
    logic [4:0] rd;
    logic       redir;
    logic       st;
    logic       mld;
    logic       rdy;
    logic [9:0] exp;
    string      name;
  } vec_t;

  vec_t sb_q[$];
  int unsigned n_vec  = 0;
  int unsigned n_fail = 0;

  function automatic vec_t mkv(input logic [4:0] rs1, input logic [4:0] rs2,
                               input logic u1, input logic u2, input logic ld,
                               input logic [4:0] rd, input logic redir,
                               input logic st, input logic mld, input logic rdy,
                               input logic [9:0] exp, input string name);
    vec_t v;
    v.rs1 = rs1; v.rs2 = rs2; v.u1 = u1; v.u2 = u2; v.ld = ld; v.rd = rd;
    v.redir = redir; v.st = st; v.mld = mld; v.rdy = rdy; v.exp = exp;
    v.name = name;
    return v;
  endfunction

  task automatic drive(input vec_t v);
    bus.id_rs1           = v.rs1;
    bus.id_rs2           = v.rs2;
    bus.id_uses_rs1      = v.u1;
    bus.id_uses_rs2      = v.u2;
    bus.ex_wb_load       = v.ld;
    bus.ex_wb_rd         = v.rd;
    bus.ex_redirect      = v.redir;
    bus.mem_memory_write = v.st;
    bus.mem_wb_load      = v.mld;
    bus.dmem_ready       = v.rdy;
  endtask

  task automatic check();
    vec_t v;
    logic [9:0] got;
    got = {bus.pc_en, bus.if_id_en, bus.if_id_flush, bus.id_ex_en, bus.id_ex_flush,
           bus.ex_mem_en, bus.ex_mem_flush, bus.mem_wb_en, bus.mem_wb_flush,
           bus.mem_fault};
    v = sb_q.pop_front();
    n_vec++;
    if (got !== v.exp) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b (t=%0t)", v.name, got, v.exp, $time);
    end
  endtask

  // One clock cycle: drive after the rising edge, compare on the falling edge.
  task automatic step(input vec_t v);
    @(posedge clk);
    #1;
    drive(v);
    sb_q.push_back(v);
    @(negedge clk);
    check();
  endtask

  vec_t tbl[10];
  vec_t idle, ld_wait, st_wait_rd, ld_ready_rd;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    idle        = mkv(5'd0, 5'd0, 0, 0, 0, 5'd0, 0, 0, 0, 1, E_NORM, "idle");
    ld_wait     = mkv(5'd0, 5'd0, 0, 0, 0, 5'd0, 0, 0, 1, 0, E_STALL, "ld_wait");
    st_wait_rd  = mkv(5'd0, 5'd0, 0, 0, 0, 5'd0, 1, 1, 0, 0, E_STALL, "stall_redir");
    ld_ready_rd = mkv(5'd0, 5'd0, 0, 0, 0, 5'd0, 1, 1, 0, 1, E_RD, "release_redir");

    tbl[0] = mkv(5'd1, 5'd2, 1, 1, 0, 5'd3, 0, 0, 0, 1, E_NORM, "tbl_idle");
    tbl[1] = mkv(5'd5, 5'd9, 1, 0, 1, 5'd5, 0, 0, 0, 1, E_LU,   "tbl_lu_rs1");
    tbl[2] = mkv(5'd4, 5'd7, 0, 1, 1, 5'd7, 0, 0, 0, 1, E_LU,   "tbl_lu_rs2");
    tbl[3] = mkv(5'd0, 5'd0, 1, 1, 1, 5'd0, 0, 0, 0, 1, E_NORM, "tbl_lu_x0");
    tbl[4] = mkv(5'd5, 5'd1, 0, 1, 1, 5'd5, 0, 0, 0, 1, E_NORM, "tbl_lu_unused");
    tbl[5] = mkv(5'd5, 5'd5, 1, 1, 0, 5'd5, 0, 0, 0, 1, E_NORM, "tbl_noload");
    tbl[6] = mkv(5'd1, 5'd2, 0, 0, 0, 5'd0, 1, 0, 0, 1, E_RD,   "tbl_redirect");
    tbl[7] = mkv(5'd5, 5'd0, 1, 0, 1, 5'd5, 1, 0, 0, 1, E_RD,   "tbl_redir_lu");
    tbl[8] = mkv(5'd0, 5'd0, 0, 0, 0, 5'd0, 0, 0, 1, 1, E_NORM, "tbl_zero_wait_ld");
    tbl[9] = mkv(5'd6, 5'd0, 1, 0, 1, 5'd6, 0, 1, 0, 1, E_LU,   "tbl_zero_wait_st_lu");

    rst = 1'b0;
    drive(idle);
    #2;
    sb_q.push_back(mkv(5'd0, 5'd0, 0, 0, 0, 5'd0, 0, 0, 0, 1, E_RESET, "reset_outputs"));
    check();
    @(negedge clk);
    rst = 1'b1;

    foreach (tbl[i]) step(tbl[i]);
    idle.name = "after_zero_wait";
    step(idle);

    // Three wait cycles, release on the fourth.
    for (int i = 0; i < 3; i++) step(ld_wait);
    step(mkv(5'd0, 5'd0, 0, 0, 0, 5'd0, 0, 0, 1, 1, E_NORM, "mem_release"));
    idle.name = "after_release";
    step(idle);

    // Redirect held across a stall is acted on only at release.
    for (int i = 0; i < 2; i++) step(st_wait_rd);
    step(ld_ready_rd);
    step(idle);

    // Timeout: MEM_TIMEOUT+1 stall cycles, one fault cycle, then RUN.
    ld_wait.name = "timeout_stall";
    for (int i = 0; i < 5; i++) step(ld_wait);
    step(mkv(5'd0, 5'd0, 0, 0, 0, 5'd0, 0, 0, 1, 0, E_FAULT, "timeout_fault"));
    idle.name = "after_fault";
    step(idle);
    ld_wait.name = "restall_after_fault";
    step(ld_wait);
    idle.name = "restall_release";
    step(mkv(5'd0, 5'd0, 0, 0, 0, 5'd0, 0, 0, 1, 1, E_NORM, "restall_release"));

    // Asynchronous reset in MEM_WAIT, away from any clock edge.
    ld_wait.name = "pre_reset_stall";
    step(ld_wait);
    step(ld_wait);
    #2;
    rst = 1'b0;
    #1;
    sb_q.push_back(mkv(5'd0, 5'd0, 0, 0, 0, 5'd0, 0, 0, 1, 0, E_RESET, "async_reset"));
    check();
    @(negedge clk);
    sb_q.push_back(mkv(5'd0, 5'd0, 0, 0, 0, 5'd0, 0, 0, 1, 0, E_RESET, "reset_held"));
    check();
    drive(idle);
    #2;
    rst = 1'b1;

    // Counter restarted: full timeout length needed again.
    ld_wait.name = "post_reset_stall";
    for (int i = 0; i < 5; i++) step(ld_wait);
    step(mkv(5'd0, 5'd0, 0, 0, 0, 5'd0, 0, 0, 1, 0, E_FAULT, "post_reset_fault"));
    idle.name = "final_idle";
    step(idle);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
